// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg
// Shared definitions for the memory-stage access unit:
//   - funct3 access-size/sign encodings
//   - access-unit FSM state type
//   - byte-enable width and an access-size decode helper
package riscv_mem_pkg;

    localparam int BE_W = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_t;

    // Any encoding with funct3[1] set (010, 011, 110, 111) is a word access;
    // otherwise funct3[0] distinguishes half (x01) from byte (x00).
    function automatic mem_size_t mem_size(input logic [2:0] f3);
        if (f3[1])
            return SZ_W;
        else if (f3[0])
            return SZ_H;
        else
            return SZ_B;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align
// Purely combinational load-data aligner: picks the addressed byte/half out
// of a read word and sign- or zero-extends it to XLEN.
//   rdata   in   XLEN  word read from data memory
//   addr_lo in   2     byte offset within the word
//   funct3  in   3     load size/sign encoding
//   result  out  XLEN  aligned, extended load value
module mem_load_align
    import riscv_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] w_byte_shift;
    logic [XLEN-1:0] w_half_shift;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;

    // Halves only come from offsets 0 or 2, so only addr_lo[1] matters there.
    assign w_byte_shift = rdata >> {addr_lo, 3'b000};
    assign w_half_shift = rdata >> {addr_lo[1], 4'b0000};
    assign w_byte       = w_byte_shift[7:0];
    assign w_half       = w_half_shift[15:0];

    always_comb begin
        result = rdata;
        case (funct3)
            F3_B:    result = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_BU:   result = {{(XLEN-8){1'b0}}, w_byte};
            F3_H:    result = {{(XLEN-16){w_half[15]}}, w_half};
            F3_HU:   result = {{(XLEN-16){1'b0}}, w_half};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// MEM-stage data-memory access controller. Turns the stage's load/store
// control into one outstanding request/ready transaction, stalls the
// pipeline until it completes, and registers aligned/extended load data.
//   clk, reset (sync, active-low)
//   MemReadM, MemWriteM, funct3M, ALUResultM, WriteDataM : MEM-stage inputs
//   ReadDataM  : registered load result
//   StallM     : combinational pipeline stall
//   MisalignM  : combinational misaligned-access flag (IDLE only)
//   dmem_req/we/addr/be/wdata : registered memory request
//   dmem_rdata/dmem_ready     : memory response
module mem_access_unit
    import riscv_mem_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [2:0]        funct3M,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [XLEN-1:0]   WriteDataM,
    output logic [XLEN-1:0]   ReadDataM,
    output logic              StallM,
    output logic              MisalignM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [BE_W-1:0]   dmem_be,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_ready
);

    mem_state_t        r_state;
    mem_state_t        w_state_next;
    logic              w_start;

    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [BE_W-1:0]   r_be;
    logic [XLEN-1:0]   r_wdata;
    logic [2:0]        r_f3;
    logic [1:0]        r_addr_lo;
    logic [XLEN-1:0]   r_read_data;

    logic              w_access;
    logic              w_misaligned;
    mem_size_t         w_size;
    logic [1:0]        w_addr_lo;
    logic [BE_W-1:0]   w_be;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_load_result;

    assign w_access  = MemReadM | MemWriteM;
    assign w_size    = mem_size(funct3M);
    assign w_addr_lo = ALUResultM[1:0];

    always_comb begin
        w_misaligned = 1'b0;
        w_be         = 4'b1111;
        w_wdata      = WriteDataM;
        case (w_size)
            SZ_B: begin
                w_be    = 4'b0001 << w_addr_lo;
                w_wdata = {4{WriteDataM[7:0]}};
            end
            SZ_H: begin
                w_misaligned = w_addr_lo[0];
                w_be         = 4'b0011 << {w_addr_lo[1], 1'b0};
                w_wdata      = {2{WriteDataM[15:0]}};
            end
            default: begin
                w_misaligned = |w_addr_lo;
            end
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access && !w_misaligned) begin
                    w_state_next = BUSY;
                    w_start      = 1'b1;
                end
            end
            BUSY: begin
                if (dmem_ready)
                    w_state_next = DONE;
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Both flags are forced low while reset is held so the pipeline is not
    // frozen by stale MEM-stage control during reset.
    assign StallM    = reset & (((r_state == IDLE) & w_access & ~w_misaligned) |
                                (r_state == BUSY));
    assign MisalignM = reset & (r_state == IDLE) & w_access & w_misaligned;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_f3        <= 3'b000;
            r_addr_lo   <= 2'b00;
            r_read_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_req     <= 1'b1;
                r_we      <= MemWriteM;
                r_addr    <= {ALUResultM[ADDR_W-1:2], 2'b00};
                r_be      <= w_be;
                r_wdata   <= w_wdata;
                r_f3      <= funct3M;
                r_addr_lo <= w_addr_lo;
            end
            if (r_state == BUSY && dmem_ready) begin
                r_req <= 1'b0;
                if (!r_we)
                    r_read_data <= w_load_result;
            end
        end
    end

    mem_load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .rdata   (dmem_rdata),
        .addr_lo (r_addr_lo),
        .funct3  (r_f3),
        .result  (w_load_result)
    );

    assign ReadDataM  = r_read_data;
    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_be    = r_be;
    assign dmem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        MisalignM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.XLEN(32), .ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MisalignM  (MisalignM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic        chk_wdata;
        logic [31:0] rd;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Monitor: pops an expectation when a request rises, checks the request
    // stays stable while it is up, and checks ReadDataM in the cycle after
    // the memory answered.
    exp_t cur;
    logic req_seen  = 1'b0;
    logic done_pend = 1'b0;
    logic have_cur  = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                req_seen  = 1'b0;
                done_pend = 1'b0;
                have_cur  = 1'b0;
            end else begin
                if (done_pend) begin
                    chk({cur.name, " ReadDataM"}, ReadDataM, cur.rd);
                    chk({cur.name, " req_dropped"}, {31'd0, dmem_req}, 32'd0);
                    done_pend = 1'b0;
                end
                if (dmem_req && !req_seen) begin
                    req_seen = 1'b1;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_req: got addr %h, expected no request", dmem_addr);
                        have_cur = 1'b0;
                    end else begin
                        cur      = exp_q.pop_front();
                        have_cur = 1'b1;
                    end
                end
                if (dmem_req && have_cur) begin
                    chk({cur.name, " addr"}, dmem_addr, cur.addr);
                    chk({cur.name, " be"}, {28'd0, dmem_be}, {28'd0, cur.be});
                    chk({cur.name, " we"}, {31'd0, dmem_we}, {31'd0, cur.we});
                    if (cur.chk_wdata)
                        chk({cur.name, " wdata"}, dmem_wdata, cur.wdata);
                    if (dmem_ready)
                        done_pend = 1'b1;
                end
                if (!dmem_req)
                    req_seen = 1'b0;
            end
        end
    end

    // One full aligned access: checks stall timing from the stimulus side,
    // port contents and load result through the monitor.
    task automatic do_access(input string name, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rdata,
                             input int waits, input logic [31:0] e_addr,
                             input logic [3:0] e_be, input logic [31:0] e_wdata,
                             input logic [31:0] e_rd);
        exp_t e;
        e.addr = e_addr; e.be = e_be; e.we = wr; e.wdata = e_wdata;
        e.chk_wdata = wr; e.rd = e_rd; e.name = name;
        @(posedge clk); #1;
        MemReadM = rd; MemWriteM = wr; funct3M = f3; ALUResultM = addr; WriteDataM = wd;
        exp_q.push_back(e);
        @(negedge clk);
        chk({name, " stall_T"}, {31'd0, StallM}, 32'd1);
        chk({name, " req_T"}, {31'd0, dmem_req}, 32'd0);
        chk({name, " misalign_T"}, {31'd0, MisalignM}, 32'd0);
        for (int w = 0; w <= waits; w++) begin
            @(posedge clk); #1;
            if (w == waits) begin
                dmem_ready = 1'b1;
                dmem_rdata = rdata;
            end
            @(negedge clk);
            chk({name, " stall_busy"}, {31'd0, StallM}, 32'd1);
            chk({name, " req_busy"}, {31'd0, dmem_req}, 32'd1);
        end
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        chk({name, " stall_done"}, {31'd0, StallM}, 32'd0);
        @(posedge clk); #1;
        MemReadM = 1'b0; MemWriteM = 1'b0;
        $display("txn %s addr=%h waits=%0d ReadDataM=%h", name, addr, waits, ReadDataM);
    endtask

    task automatic do_misalign(input string name, input logic [2:0] f3, input logic [31:0] addr);
        @(posedge clk); #1;
        MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = f3; ALUResultM = addr;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk({name, " misalign"}, {31'd0, MisalignM}, 32'd1);
            chk({name, " stall"}, {31'd0, StallM}, 32'd0);
            chk({name, " req"}, {31'd0, dmem_req}, 32'd0);
            @(posedge clk); #1;
        end
        MemReadM = 1'b0;
        @(negedge clk);
        chk({name, " misalign_clear"}, {31'd0, MisalignM}, 32'd0);
        $display("txn %s addr=%h misaligned", name, addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010;
        ALUResultM = 32'h100; WriteDataM = 32'h0;
        dmem_rdata = 32'h0; dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst StallM", {31'd0, StallM}, 32'd0);
        chk("rst MisalignM", {31'd0, MisalignM}, 32'd0);
        chk("rst dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst dmem_we", {31'd0, dmem_we}, 32'd0);
        chk("rst dmem_addr", dmem_addr, 32'd0);
        chk("rst dmem_be", {28'd0, dmem_be}, 32'd0);
        chk("rst dmem_wdata", dmem_wdata, 32'd0);
        chk("rst ReadDataM", ReadDataM, 32'd0);
        MemReadM = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;

        do_access("LW_100", 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0,
                  32'h100, 4'b1111, 32'h0, 32'hDEADBEEF);
        do_access("LB_103", 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0,
                  32'h100, 4'b1000, 32'h0, 32'hFFFFFF80);
        do_access("LBU_103", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0,
                  32'h100, 4'b1000, 32'h0, 32'h00000080);
        do_access("LH_102", 1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 1,
                  32'h100, 4'b1100, 32'h0, 32'hFFFF80FF);
        do_access("LHU_000", 1, 0, 3'b101, 32'h000, 32'h0, 32'h80FF9234, 0,
                  32'h000, 4'b0011, 32'h0, 32'h00009234);
        do_access("LB_001", 1, 0, 3'b000, 32'h001, 32'h0, 32'h80FF1234, 2,
                  32'h000, 4'b0010, 32'h0, 32'h00000012);
        do_access("SH_202", 0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h77777777, 3,
                  32'h200, 4'b1100, 32'hABCDABCD, 32'h00000012);
        do_access("SB_013", 0, 1, 3'b000, 32'h013, 32'h1234565A, 32'h0, 0,
                  32'h010, 4'b1000, 32'h5A5A5A5A, 32'h00000012);
        do_access("SW_BOTH_010", 1, 1, 3'b010, 32'h010, 32'hCAFEF00D, 32'h11111111, 0,
                  32'h010, 4'b1111, 32'hCAFEF00D, 32'h00000012);
        do_access("LW_F3_011", 1, 0, 3'b011, 32'h020, 32'h0, 32'h01234567, 0,
                  32'h020, 4'b1111, 32'h0, 32'h01234567);

        do_misalign("LW_101", 3'b010, 32'h101);
        do_misalign("LH_203", 3'b001, 32'h203);
        chk("misalign ReadDataM_kept", ReadDataM, 32'h01234567);

        // Reset while a request is outstanding; memory never answers.
        begin
            exp_t e;
            e.addr = 32'h40; e.be = 4'b1111; e.we = 1'b0; e.wdata = 32'h0;
            e.chk_wdata = 1'b0; e.rd = 32'h0; e.name = "LW_40_abort";
            @(posedge clk); #1;
            MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010; ALUResultM = 32'h40;
            exp_q.push_back(e);
            @(negedge clk);
            chk("abort stall_T", {31'd0, StallM}, 32'd1);
            @(posedge clk); #1;
            @(negedge clk);
            chk("abort req_busy", {31'd0, dmem_req}, 32'd1);
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            chk("abort stall_in_reset", {31'd0, StallM}, 32'd0);
            @(posedge clk); #1;
            MemReadM = 1'b0;
            @(negedge clk);
            chk("abort req_after_reset", {31'd0, dmem_req}, 32'd0);
            chk("abort ReadDataM_after_reset", ReadDataM, 32'd0);
            @(posedge clk); #1;
            reset = 1'b1;
            dmem_ready = 1'b1;
            dmem_rdata = 32'hFFFFFFFF;
            @(negedge clk);
            chk("late_ready req", {31'd0, dmem_req}, 32'd0);
            chk("late_ready stall", {31'd0, StallM}, 32'd0);
            @(posedge clk); #1;
            dmem_ready = 1'b0;
            @(negedge clk);
            chk("late_ready ReadDataM", ReadDataM, 32'd0);
            chk("late_ready req_after", {31'd0, dmem_req}, 32'd0);
            $display("txn LW_40_abort addr=00000040 reset in BUSY, ReadDataM=%h", ReadDataM);
        end

        do_access("LW_44_recover", 1, 0, 3'b010, 32'h044, 32'h0, 32'h0BADF00D, 1,
                  32'h044, 4'b1111, 32'h0, 32'h0BADF00D);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access controller sitting between the EX/MEM pipeline register and the MEM/WB register. It converts the MEM-stage load/store control (MemWriteM, MemReadM, funct3M) and ALU address into a single-outstanding request/ready transaction on the data-memory port. It aligns and sign- or zero-extends load data into ReadDataM and stalls the pipeline until the access completes. Misaligned accesses are flagged and never reach memory.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- ADDR_W, 32, byte-address width.

- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-low reset; one clock.
- MemReadM  in  1  MEM-stage instruction is a load.
- MemWriteM  in  1  MEM-stage instruction is a store.
- funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ALUResultM  in  ADDR_W  byte address.
- WriteDataM  in  XLEN  store data, right-justified.
- ReadDataM  out  XLEN  aligned/extended load result, registered.
- StallM  out  1  hold IF..MEM stages; combinational.
- MisalignM  out  1  misaligned access detected this cycle; combinational.
- dmem_req  out  1  request valid, registered.
- dmem_we  out  1  write request, registered.
- dmem_addr  out  ADDR_W  word-aligned address (bits [1:0]=0), registered.
- dmem_be  out  4  byte enables, registered.
- dmem_wdata  out  XLEN  lane-replicated store data, registered.
- dmem_rdata  in  XLEN  read word, valid with dmem_ready.
- dmem_ready  in  1  transaction complete.

## Operation
- Access = MemReadM | MemWriteM. If both are asserted, the access is a store.
- Misaligned conditions:
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠0.
- funct3 011/110/111 are treated as W.
- FSM states and transitions:
  - IDLE:
    - Aligned access → latch dmem_addr={addr[31:2],2'b00}, dmem_be, dmem_wdata, dmem_we, funct3, addr[1:0]; set dmem_req=1; go to BUSY.
    - Misaligned access → MisalignM=1, no request, no store, stay in IDLE.
    - No access → stay in IDLE.
  - BUSY:
    - Hold all dmem_* outputs stable.
    - On dmem_ready=1, clear dmem_req. For a load, register the aligned/extended data into ReadDataM. Go to DONE.
  - DONE: StallM=0 for exactly one cycle so the instruction advances. No new access is started. Go to IDLE.
- StallM = (IDLE & aligned access) | BUSY.
- Byte enables:
  - B: 4'b0001 << addr[1:0].
  - H: 4'b0011 << {addr[1],1'b0}.
  - W: 4'b1111.
- Store data lane replication:
  - B: {4{wd[7:0]}}.
  - H: {2{wd[15:0]}}.
  - W: wd.
- Load alignment: select the byte or half by addr[1:0]. B and H sign-extend; BU and HU zero-extend.
- ReadDataM keeps its value after stores and while idle; it updates only when a load completes.
- dmem_ready is ignored outside BUSY.

## Timing
- Reset values: FSM=IDLE; dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata and ReadDataM all 0. StallM=0 and MisalignM=0 while reset is low.
- Access seen in IDLE at cycle T:
  - StallM=1 at T.
  - dmem_req=1 from T+1.
  - With dmem_ready at T+1+N, ReadDataM is valid and StallM=0 at T+2+N.
  - The pipeline advances at the end of that cycle.
  - Minimum access latency is 3 cycles (N=0).
- dmem_req drops in the cycle after ready is sampled. There are no back-to-back requests; the minimum gap is 2 idle cycles on the port.
- Reset asserted in BUSY: next cycle is IDLE with dmem_req=0. The in-flight memory response is discarded.
- MisalignM is valid only in IDLE. It never coincides with dmem_req rising.

## Structure
- Package riscv_mem_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - FSM state enum {IDLE, BUSY, DONE}.
  - Byte-enable width constant (4).
- One combinational sub-module, mem_load_align (rdata, addr_lo, funct3 → extended XLEN result). The same function also serves the MEM/WB path if needed.
- Byte-enable and store-lane logic stay inline.

## Test plan
- LW from 0x100, dmem_rdata=0xDEADBEEF, ready at first BUSY cycle:
  - dmem_addr=0x100, be=1111, 3 cycles of latency.
  - ReadDataM=0xDEADBEEF.
  - StallM high for 2 cycles, then low for 1.
- LB and LBU from 0x103, rdata=0x80FF1234:
  - be=1000.
  - LB → ReadDataM=0xFFFFFF80; LBU → 0x00000080.
- SH of 0x0000ABCD at 0x202, 3 wait states:
  - dmem_we=1, addr=0x200, be=1100, wdata=0xABCDABCD.
  - Outputs stable for 4 BUSY cycles.
  - ReadDataM unchanged.
- LW at 0x101:
  - MisalignM=1, StallM=0, dmem_req stays 0 for the whole cycle.
  - No state change.
- Reset pulled low during BUSY (dmem_ready never asserted):
  - Next cycle FSM=IDLE, dmem_req=0, ReadDataM=0.
  - A later ready pulse is ignored.
- MemReadM and MemWriteM both high, SW at 0x10:
  - A write occurs (dmem_we=1, be=1111).
  - ReadDataM is not updated.
